// File: rtl/multi_counter_max.sv
// multi_counter_max: NCH independent up-counters, each with a programmable
// terminal value and mode (legacy, auto-reload, one-shot). It produces a
// per-channel terminal flag, a one-cycle terminal pulse and an interrupt
// aggregated over the reload/one-shot channels.
module multi_counter_max #(
    parameter int unsigned DW  = 16,
    parameter int unsigned NCH = 4,
    localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [SW-1:0]     wsel,
    input  logic [DW-1:0]     wmax,
    input  logic [1:0]        wmode,
    input  logic [NCH-1:0]    ce,
    input  logic [NCH-1:0]    clr,
    output logic [NCH-1:0]    of,
    output logic [NCH-1:0]    tc,
    output logic [NCH*DW-1:0] dout,
    output logic              irq
);

    localparam logic [1:0] ModeLegacy = 2'd0;
    localparam logic [1:0] ModeReload = 2'd1;
    localparam logic [1:0] ModeOneShot = 2'd2;

    logic [DW-1:0]  cnt_q  [NCH];
    logic [DW-1:0]  cnt_d  [NCH];
    logic [DW-1:0]  max_q  [NCH];
    logic [DW-1:0]  max_d  [NCH];
    logic [1:0]     mode_q [NCH];
    logic [1:0]     mode_d [NCH];
    logic [NCH-1:0] of_q, of_d;
    logic [NCH-1:0] tc_q, tc_d;
    logic [NCH-1:0] term;

    // Per-channel next state: config write, then clr > ce > hold.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            max_d[i]  = max_q[i];
            mode_d[i] = mode_q[i];
            of_d[i]   = of_q[i];
            tc_d[i]   = 1'b0;
            // Compare one bit wider so max=0 can never match an all-ones count.
            term[i]   = (({1'b0, cnt_q[i]} + (DW+1)'(1)) == {1'b0, max_q[i]});

            // Out-of-range selects never match any channel index.
            if (we && (wsel == SW'(i))) begin
                max_d[i]  = wmax;
                mode_d[i] = (wmode == 2'd3) ? ModeLegacy : wmode;
            end

            if (clr[i]) begin
                cnt_d[i] = '0;
                of_d[i]  = 1'b0;
            end else if (ce[i]) begin
                case (mode_q[i])
                    ModeReload: begin
                        if (term[i]) begin
                            cnt_d[i] = '0;
                            of_d[i]  = 1'b1;
                            tc_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + DW'(1);
                        end
                    end
                    ModeOneShot: begin
                        if (!of_q[i]) begin
                            if (term[i]) begin
                                cnt_d[i] = max_q[i];
                                of_d[i]  = 1'b1;
                                tc_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + DW'(1);
                            end
                        end
                    end
                    default: begin
                        if (of_q[i]) begin
                            cnt_d[i] = '0;
                            of_d[i]  = 1'b0;
                        end else if (term[i]) begin
                            cnt_d[i] = max_q[i];
                            of_d[i]  = 1'b1;
                            tc_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + DW'(1);
                        end
                    end
                endcase
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                max_q[i]  <= '0;
                mode_q[i] <= ModeLegacy;
            end
            of_q <= '0;
            tc_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                max_q[i]  <= max_d[i];
                mode_q[i] <= mode_d[i];
            end
            of_q <= of_d;
            tc_q <= tc_d;
        end
    end

    // Output packing and interrupt aggregation straight from registers.
    always_comb begin
        dout = '0;
        irq  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            dout[i*DW +: DW] = cnt_q[i];
            if (of_q[i] && ((mode_q[i] == ModeReload) || (mode_q[i] == ModeOneShot))) begin
                irq = 1'b1;
            end
        end
    end

    assign of = of_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_multi_counter_max.sv
// Self-checking bench for multi_counter_max. Each scenario pushes the expected
// {count, of, tc, irq} of the channel under test into a scoreboard queue when it
// drives a cycle, then pops and compares once the DUT has clocked.
module tb_multi_counter_max;

    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int SW  = 2;

    logic              clk;
    logic              rstn;
    logic              we;
    logic [SW-1:0]     wsel;
    logic [DW-1:0]     wmax;
    logic [1:0]        wmode;
    logic [NCH-1:0]    ce;
    logic [NCH-1:0]    clr;
    logic [NCH-1:0]    of;
    logic [NCH-1:0]    tc;
    logic [NCH*DW-1:0] dout;
    logic              irq;

    int checks = 0;
    int passes = 0;

    logic [DW+2:0] sb_q[$];

    multi_counter_max #(.DW(DW), .NCH(NCH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .we   (we),
        .wsel (wsel),
        .wmax (wmax),
        .wmode(wmode),
        .ce   (ce),
        .clr  (clr),
        .of   (of),
        .tc   (tc),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle configuration write; ce/clr are left as the caller set them.
    task automatic cfg(input int c, input int m, input int md);
        we    = 1'b1;
        wsel  = SW'(c);
        wmax  = DW'(m);
        wmode = 2'(md);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        we = 1'b0; wsel = '0; wmax = '0; wmode = '0; ce = '0; clr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout !== '0) $display("FAIL reset_dout: got %h want 0", dout); else passes++;
        checks++; if (of !== '0) $display("FAIL reset_of: got %b want 0", of); else passes++;
        checks++; if (tc !== '0) $display("FAIL reset_tc: got %b want 0", tc); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passes++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_legacy();
        int ecnt[6];
        int eof[6];
        logic [DW+2:0] obs, exp_v;
        ecnt = '{1, 2, 3, 0, 1, 2};
        eof  = '{0, 0, 1, 0, 0, 0};
        cfg(0, 3, 0);
        for (int k = 0; k < 6; k++) begin
            ce = 4'b0001;
            sb_q.push_back({DW'(ecnt[k]), 1'(eof[k]), 1'(eof[k]), 1'b0});
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs = {dout[0 +: DW], of[0], tc[0], irq};
            checks++;
            if (obs !== exp_v) $display("FAIL legacy step %0d: got %h want %h", k, obs, exp_v);
            else passes++;
        end
        ce = '0;
    endtask

    // ch0 sits at 2 with max=3; the new max=5 lands on the same edge as the terminal.
    task automatic test_write_collision();
        int ecnt[8];
        int eof[8];
        logic [DW+2:0] obs, exp_v;
        ecnt = '{3, 0, 1, 2, 3, 4, 5, 0};
        eof  = '{1, 0, 0, 0, 0, 0, 1, 0};
        for (int k = 0; k < 8; k++) begin
            we = (k == 0); wsel = 2'd0; wmax = 16'd5; wmode = 2'd0;
            ce = 4'b0001;
            sb_q.push_back({DW'(ecnt[k]), 1'(eof[k]), 1'(eof[k]), 1'b0});
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs = {dout[0 +: DW], of[0], tc[0], irq};
            checks++;
            if (obs !== exp_v) $display("FAIL collision step %0d: got %h want %h", k, obs, exp_v);
            else passes++;
        end
        we = 1'b0; ce = '0;
    endtask

    task automatic test_autoreload();
        int ecnt[9];
        int eof[9];
        int etc[9];
        logic [DW+2:0] obs, exp_v;
        ecnt = '{1, 2, 3, 0, 1, 2, 3, 0, 0};
        eof  = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
        etc  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        cfg(1, 4, 1);
        for (int k = 0; k < 9; k++) begin
            ce  = (k < 8) ? 4'b0010 : 4'b0000;
            clr = (k < 8) ? 4'b0000 : 4'b0010;
            sb_q.push_back({DW'(ecnt[k]), 1'(eof[k]), 1'(etc[k]), 1'(eof[k])});
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs = {dout[DW +: DW], of[1], tc[1], irq};
            checks++;
            if (obs !== exp_v) $display("FAIL autoreload step %0d: got %h want %h", k, obs, exp_v);
            else passes++;
        end
        ce = '0; clr = '0;
    endtask

    task automatic test_oneshot();
        int ecnt[6];
        int eof[6];
        int etc[6];
        logic [DW+2:0] obs, exp_v;
        ecnt = '{1, 2, 2, 2, 2, 0};
        eof  = '{0, 1, 1, 1, 1, 0};
        etc  = '{0, 1, 0, 0, 0, 0};
        cfg(2, 2, 2);
        for (int k = 0; k < 6; k++) begin
            ce  = 4'b0100;
            clr = (k < 5) ? 4'b0000 : 4'b0100;
            sb_q.push_back({DW'(ecnt[k]), 1'(eof[k]), 1'(etc[k]), 1'(eof[k])});
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs = {dout[2*DW +: DW], of[2], tc[2], irq};
            checks++;
            if (obs !== exp_v) $display("FAIL oneshot step %0d: got %h want %h", k, obs, exp_v);
            else passes++;
        end
        ce = '0; clr = '0;
    endtask

    // max=0 never terminates: count all the way to all-ones and wrap silently.
    task automatic test_wrap();
        logic seen_tc;
        logic [DW+2:0] obs, exp_v;
        seen_tc = 1'b0;
        cfg(3, 0, 0);
        ce = 4'b1000;
        for (int k = 0; k < 65535; k++) begin
            @(posedge clk);
            #1;
            if (tc[3] || of[3]) seen_tc = 1'b1;
        end
        checks++;
        if (seen_tc !== 1'b0) $display("FAIL wrap_no_event: got %b want 0", seen_tc);
        else passes++;
        sb_q.push_back({16'hFFFF, 1'b0, 1'b0, 1'b0});
        exp_v = sb_q.pop_front();
        obs = {dout[3*DW +: DW], of[3], tc[3], irq};
        checks++;
        if (obs !== exp_v) $display("FAIL wrap_allones: got %h want %h", obs, exp_v);
        else passes++;
        for (int k = 0; k < 6; k++) begin
            ce  = (k >= 1 && k <= 3) ? 4'b1000 : 4'b0000;
            clr = (k == 5) ? 4'b1000 : 4'b0000;
            if (k == 0) ce = 4'b1000;
            case (k)
                0:       sb_q.push_back({16'h0000, 1'b0, 1'b0, 1'b0});
                4:       sb_q.push_back({16'h0000, 1'b1, 1'b0, 1'b1});
                5:       sb_q.push_back({16'h0000, 1'b0, 1'b0, 1'b0});
                default: sb_q.push_back({16'h0000, 1'b1, 1'b1, 1'b1});
            endcase
            @(posedge clk);
            #1;
            exp_v = sb_q.pop_front();
            obs = {dout[3*DW +: DW], of[3], tc[3], irq};
            checks++;
            if (obs !== exp_v) $display("FAIL wrap step %0d: got %h want %h", k, obs, exp_v);
            else passes++;
            // Reprogram to max=1 auto-reload with ce low on the write edge.
            if (k == 0) begin
                ce = '0;
                cfg(3, 1, 1);
            end
        end
        ce = '0; clr = '0;
    endtask

    task automatic test_reset_mid();
        cfg(0, 1, 2);
        cfg(1, 1, 1);
        cfg(2, 1, 2);
        cfg(3, 1, 2);
        ce = 4'b1111;
        @(posedge clk);
        #1;
        checks++;
        if (of !== 4'b1111 || irq !== 1'b1)
            $display("FAIL pre_reset_of: got of=%b irq=%b want of=1111 irq=1", of, irq);
        else passes++;
        #3;
        rstn = 1'b0;
        #1;
        checks++; if (dout !== '0) $display("FAIL async_dout: got %h want 0", dout); else passes++;
        checks++; if (of !== '0) $display("FAIL async_of: got %b want 0", of); else passes++;
        checks++; if (tc !== '0) $display("FAIL async_tc: got %b want 0", tc); else passes++;
        checks++; if (irq !== 1'b0) $display("FAIL async_irq: got %b want 0", irq); else passes++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dout !== {4{16'd3}}) $display("FAIL post_reset_cnt: got %h want %h", dout, {4{16'd3}});
        else passes++;
        checks++;
        if ({of, tc, irq} !== 9'b0)
            $display("FAIL post_reset_flags: got of=%b tc=%b irq=%b want 0", of, tc, irq);
        else passes++;
        ce = '0;
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_write_collision();
        test_autoreload();
        test_oneshot();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
